load_store_unit: RTL and testbench

Memory-access stage that sits behind the execute stage. It takes the effective address and store operand produced for a load or store and runs a single request/ready transaction on the data-memory bus. For stores it generates byte enables and lane-replicated write data. For loads it extracts the addressed byte, halfword or word and sign- or zero-extends it into a 32-bit writeback value. One transaction is in flight at a time; the core sequencer starts it and waits for `done_o`.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Decode-net bit positions shared by the core, plus the data-memory bus
// interface between the load/store unit (master) and data memory (slave).
package riscv_defs;
  localparam int DECODE_W = 46;
  localparam int IS_ADD   = 0;
  localparam int IS_LB    = 20;
  localparam int IS_LBU   = 21;
  localparam int IS_LH    = 22;
  localparam int IS_LHU   = 23;
  localparam int IS_LW    = 24;
  localparam int IS_SB    = 25;
  localparam int IS_SH    = 26;
  localparam int IS_SW    = 27;
endpackage

interface load_store_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one request/ready transaction per start, formats
// store lanes/byte enables and extends load results into a 32-bit writeback.
module load_store_unit
  import riscv_defs::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [DECODE_W-1:0] decode_net_i,
  input  logic [31:0]         address_i,
  input  logic [31:0]         store_data_i,
  load_store_unit_if.master   mem,
  output logic [31:0]         load_data_o,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        is_load_q, is_load_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        dec_mem, dec_load, dec_unsigned, misaligned, timeout_hit;
  size_e       dec_size;
  logic [31:0] st_wdata, load_ext;
  logic [3:0]  st_be;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  wire unused_decode = ^decode_net_i;

  // Priority order when several IS_* bits are set: LW, LH, LHU, LB, LBU, SW, SH, SB.
  always_comb begin
    dec_mem      = 1'b1;
    dec_load     = 1'b1;
    dec_unsigned = 1'b0;
    dec_size     = SZ_W;
    if (decode_net_i[IS_LW]) begin
      dec_size = SZ_W;
    end else if (decode_net_i[IS_LH]) begin
      dec_size = SZ_H;
    end else if (decode_net_i[IS_LHU]) begin
      dec_size     = SZ_H;
      dec_unsigned = 1'b1;
    end else if (decode_net_i[IS_LB]) begin
      dec_size = SZ_B;
    end else if (decode_net_i[IS_LBU]) begin
      dec_size     = SZ_B;
      dec_unsigned = 1'b1;
    end else if (decode_net_i[IS_SW]) begin
      dec_load = 1'b0;
      dec_size = SZ_W;
    end else if (decode_net_i[IS_SH]) begin
      dec_load = 1'b0;
      dec_size = SZ_H;
    end else if (decode_net_i[IS_SB]) begin
      dec_load = 1'b0;
      dec_size = SZ_B;
    end else begin
      dec_mem  = 1'b0;
      dec_load = 1'b0;
    end
  end

  assign misaligned = ((dec_size == SZ_H) && address_i[0]) ||
                      ((dec_size == SZ_W) && (address_i[1:0] != 2'b00));

  always_comb begin
    st_wdata = store_data_i;
    st_be    = 4'b1111;
    case (dec_size)
      SZ_B: begin
        st_wdata = {4{store_data_i[7:0]}};
        st_be    = 4'b0001 << address_i[1:0];
      end
      SZ_H: begin
        st_wdata = {2{store_data_i[15:0]}};
        st_be    = address_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign lane_b = mem.mem_rdata_i[{addr_lo_q, 3'b000} +: 8];
  assign lane_h = mem.mem_rdata_i[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_B:    load_ext = unsigned_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_H:    load_ext = unsigned_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem.mem_rdata_i;
    endcase
  end

  // Ready on the expiry cycle is checked first, so it still completes normally.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    is_load_d   = is_load_q;
    unsigned_d  = unsigned_q;
    addr_lo_d   = addr_lo_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load_data_d = '0;
          err_d       = 1'b0;
          is_load_d   = dec_load;
          size_d      = dec_size;
          unsigned_d  = dec_unsigned;
          addr_lo_d   = address_i[1:0];
          if (!dec_mem) begin
            state_d = DONE;
          end else if (misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = !dec_load;
            addr_d  = {address_i[31:2], 2'b00};
            wdata_d = dec_load ? 32'h0 : st_wdata;
            be_d    = dec_load ? 4'b1111 : st_be;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready_i || timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          if (mem.mem_ready_i) begin
            if (is_load_q) load_data_d = load_ext;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      size_q      <= SZ_B;
      is_load_q   <= 1'b0;
      unsigned_q  <= 1'b0;
      addr_lo_q   <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      is_load_q   <= is_load_d;
      unsigned_q  <= unsigned_d;
      addr_lo_q   <= addr_lo_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_be_o    = be_q;
  assign load_data_o     = load_data_q;
  assign err_o           = err_q;
  assign done_o          = (state_q == DONE);
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// and completion values; a negedge monitor compares them as the DUT responds.
module tb_load_store_unit;
  import riscv_defs::*;

  localparam int TO = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic [DECODE_W-1:0] decode_net_i = '0;
  logic [31:0]         address_i = '0;
  logic [31:0]         store_data_i = '0;
  logic [31:0]         load_data_o;
  logic                done_o, err_o, busy_o;

  load_store_unit_if mem();

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .decode_net_i (decode_net_i),
    .address_i    (address_i),
    .store_data_i (store_data_i),
    .mem          (mem.master),
    .load_data_o  (load_data_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          done_cyc;
    int          reqs;
    logic [31:0] load;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   req_seen = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Memory model: ready after ready_delay request cycles; negative means never.
  int          ready_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] rdata_cfg = '0;
  assign mem.mem_rdata_i = rdata_cfg;
  initial mem.mem_ready_i = 1'b0;

  always @(posedge clk_i) begin
    #1;
    if (mem.mem_req_o) begin
      mem.mem_ready_i = (ready_delay >= 0) && (wait_cnt >= ready_delay);
      wait_cnt++;
    end else begin
      mem.mem_ready_i = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: compares bus fields each request cycle and results on done_o.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      req_seen = 0;
    end else begin
      if (mem.mem_req_o) begin
        if (exp_q.size() == 0) begin
          check32("unexpected_req", 32'd1, 32'd0);
        end else begin
          check32("bus_addr", mem.mem_addr_o, exp_q[0].addr);
          check32("bus_we", {31'b0, mem.mem_we_o}, {31'b0, exp_q[0].we});
          check32("bus_be", {28'b0, mem.mem_be_o}, {28'b0, exp_q[0].be});
          if (exp_q[0].chk_wdata) check32("bus_wdata", mem.mem_wdata_o, exp_q[0].wdata);
          check32("busy_in_req", {31'b0, busy_o}, 32'd1);
        end
        req_seen++;
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check32("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check32("done_cycle", cyc, mon_e.done_cyc);
          check32("req_cycles", req_seen, mon_e.reqs);
          check32("err", {31'b0, err_o}, {31'b0, mon_e.err});
          check32("load_data", load_data_o, mon_e.load);
          check32("bus_idle_in_done", {31'b0, mem.mem_req_o}, 32'd0);
        end
        req_seen = 0;
      end
    end
  end

  function automatic logic [DECODE_W-1:0] dec1(input int b);
    logic [DECODE_W-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic exp_t mk(input logic [31:0] load, input logic err, input int reqs,
                              input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic chk_wdata,
                              input logic [3:0] be);
    exp_t e;
    e.done_cyc  = 0;
    e.reqs      = reqs;
    e.load      = load;
    e.err       = err;
    e.addr      = addr;
    e.we        = we;
    e.wdata     = wdata;
    e.chk_wdata = chk_wdata;
    e.be        = be;
    return e;
  endfunction

  // Drives a one-cycle start; lat is the expected done_o offset from the start cycle.
  task automatic issue(input logic [DECODE_W-1:0] dec, input logic [31:0] addr,
                       input logic [31:0] sd, input int lat, input exp_t e, input bit push);
    exp_t ee;
    @(posedge clk_i);
    #1;
    decode_net_i = dec;
    address_i    = addr;
    store_data_i = sd;
    start_i      = 1'b1;
    if (push) begin
      ee          = e;
      ee.done_cyc = cyc + lat;
      exp_q.push_back(ee);
    end
    @(posedge clk_i);
    #1;
    start_i      = 1'b0;
    decode_net_i = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk_i);
      n++;
    end
    check32("wait_done_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk_i);
  endtask

  initial begin
    #1;
    check32("rst_done", {31'b0, done_o}, 32'd0);
    check32("rst_busy", {31'b0, busy_o}, 32'd0);
    check32("rst_req", {31'b0, mem.mem_req_o}, 32'd0);
    check32("rst_be", {28'b0, mem.mem_be_o}, 32'd0);
    check32("rst_load", load_data_o, 32'd0);
    check32("rst_err", {31'b0, err_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Byte loads, ready on the first request cycle.
    ready_delay = 0; rdata_cfg = 32'h80FF_1234;
    issue(dec1(IS_LB), 32'h1003, 32'h0, 2, mk(32'hFFFF_FF80, 0, 1, 32'h1000, 0, 0, 0, 4'hF), 1);
    wait_done();
    issue(dec1(IS_LBU), 32'h1003, 32'h0, 2, mk(32'h0000_0080, 0, 1, 32'h1000, 0, 0, 0, 4'hF), 1);
    wait_done();

    // Halfword store with three wait cycles.
    ready_delay = 3;
    issue(dec1(IS_SH), 32'h2002, 32'hDEAD_BEEF, 5, mk(32'h0, 0, 4, 32'h2000, 1, 32'hBEEF_BEEF, 1, 4'b1100), 1);
    wait_done();

    // Misaligned accesses and an accepted odd byte store.
    ready_delay = 0;
    issue(dec1(IS_LW), 32'h3002, 32'h0, 1, mk(32'h0, 1, 0, 0, 0, 0, 0, 0), 1);
    wait_done();
    issue(dec1(IS_SH), 32'h3001, 32'h1234_5678, 1, mk(32'h0, 1, 0, 0, 0, 0, 0, 0), 1);
    wait_done();
    issue(dec1(IS_SB), 32'h3001, 32'h1234_5678, 2, mk(32'h0, 0, 1, 32'h3000, 1, 32'h7878_7878, 1, 4'b0010), 1);
    wait_done();

    // Timeout, then ready exactly on the expiry cycle.
    ready_delay = -1; rdata_cfg = 32'hFFFF_FFFF;
    issue(dec1(IS_LW), 32'h0, 32'h0, TO + 2, mk(32'h0, 1, TO + 1, 32'h0, 0, 0, 0, 4'hF), 1);
    wait_done();
    repeat (3) @(posedge clk_i);
    #1;
    check32("err_held", {31'b0, err_o}, 32'd1);
    check32("load_held_zero", load_data_o, 32'd0);
    ready_delay = TO; rdata_cfg = 32'hCAFE_F00D;
    issue(dec1(IS_LW), 32'h0, 32'h0, TO + 2, mk(32'hCAFE_F00D, 0, TO + 1, 32'h0, 0, 0, 0, 4'hF), 1);
    wait_done();

    // Reset in the second request cycle.
    ready_delay = -1;
    issue(dec1(IS_LW), 32'h0, 32'h0, 0, mk(32'h0, 0, 0, 32'h0, 0, 0, 0, 4'hF), 1);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check32("rst_mid_req", {31'b0, mem.mem_req_o}, 32'd0);
    check32("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    check32("rst_mid_done", {31'b0, done_o}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);

    // Halfword loads after reset, then a word store.
    ready_delay = 0; rdata_cfg = 32'h8001_0000;
    issue(dec1(IS_LHU), 32'h4002, 32'h0, 2, mk(32'h0000_8001, 0, 1, 32'h4000, 0, 0, 0, 4'hF), 1);
    wait_done();
    issue(dec1(IS_LH), 32'h4002, 32'h0, 2, mk(32'hFFFF_8001, 0, 1, 32'h4000, 0, 0, 0, 4'hF), 1);
    wait_done();
    issue(dec1(IS_SW), 32'h5004, 32'hA5A5_5A5A, 2, mk(32'h0, 0, 1, 32'h5004, 1, 32'hA5A5_5A5A, 1, 4'hF), 1);
    wait_done();

    // Start while busy is ignored.
    ready_delay = 2; rdata_cfg = 32'h1122_3344;
    issue(dec1(IS_LW), 32'h6000, 32'h0, 4, mk(32'h1122_3344, 0, 3, 32'h6000, 0, 0, 0, 4'hF), 1);
    issue(dec1(IS_SW), 32'h6100, 32'hFFFF_FFFF, 0, mk(32'h0, 0, 0, 0, 0, 0, 0, 0), 0);
    wait_done();
    repeat (5) @(posedge clk_i);

    // Non-memory op, then LW winning over SB when both are set.
    issue(dec1(IS_ADD), 32'h0, 32'h0, 1, mk(32'h0, 0, 0, 0, 0, 0, 0, 0), 1);
    wait_done();
    ready_delay = 0; rdata_cfg = 32'h0BAD_F00D;
    issue(dec1(IS_LW) | dec1(IS_SB), 32'h7000, 32'h55, 2, mk(32'h0BAD_F00D, 0, 1, 32'h7000, 0, 0, 0, 4'hF), 1);
    wait_done();
    repeat (3) @(posedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
